cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, number of key/value entries (power of two, >=2).
REQ-002 SHALL have parameter KEY_WIDTH, default 61, key width in bits.
REQ-003 SHALL have parameter VALUE_WIDTH, default 128, value width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port valid_in  input  1  request valid from the OBI interface.
REQ-007 SHALL have port operation_in  input  3  opcode: 0 NOOP, 1 GET, 2 PUT, 3 DELETE; 4-7 reserved.
REQ-008 SHALL have port key_in  input  KEY_WIDTH  request key.
REQ-009 SHALL have port value_in  input  VALUE_WIDTH  PUT data.
REQ-010 SHALL have port ready_out  output  1  controller idle, can accept a request.
REQ-011 SHALL have port done_out  output  1  one-cycle completion pulse.
REQ-012 SHALL have port op_succ_out  output  1  result status of last completed request.
REQ-013 SHALL have port value_out  output  VALUE_WIDTH  GET result of last completed request.
REQ-014 SHALL have port count_out  output  $clog2(NUM_ENTRIES+1)  number of valid entries.

Function
REQ-015 SHALL hold NUM_ENTRIES entries internally, each a valid bit, key register and value register.
REQ-016 SHALL implement states IDLE, SCAN, COMMIT, RESP; ready_out = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where state is IDLE and valid_in = 1, registering operation_in, key_in, value_in; valid_in outside IDLE is ignored.
REQ-018 SHALL in SCAN compare one entry per cycle, index 0 to NUM_ENTRIES-1, recording first valid entry with matching key (hit) and lowest-index invalid entry (free); SCAN lasts exactly NUM_ENTRIES cycles, no early exit.
REQ-019 SHALL in COMMIT (1 cycle) update storage: PUT hit overwrites value; PUT miss with free slot writes key, value, sets valid, count +1; DELETE hit clears valid, count -1; GET, NOOP, reserved opcodes modify nothing.
REQ-020 SHALL assert done_out for exactly the one RESP cycle, i.e. NUM_ENTRIES+2 cycles after the accepting edge, then return to IDLE.
REQ-021 SHALL update op_succ_out and value_out on entering RESP and hold them until the next RESP.
REQ-022 SHALL set op_succ_out = 1 for GET hit, PUT hit, PUT miss with slot written, DELETE hit; 0 for all misses, PUT with no slot, NOOP, reserved opcodes.
REQ-023 SHALL drive value_out = stored value on GET hit, all zeros otherwise.
REQ-024 SHALL never let count_out exceed NUM_ENTRIES or underflow below 0.
REQ-025 SHALL support back-to-back requests: valid_in held high yields acceptance in the IDLE cycle after RESP (one request per NUM_ENTRIES+3 cycles).

Reset
REQ-026 SHALL on rst = 1, immediately and regardless of state: state = IDLE, all valid bits = 0, count_out = 0, done_out = 0, op_succ_out = 0, value_out = 0, ready_out = 1 while not busy.
REQ-027 SHALL abort an in-flight request on reset with no storage update and no done_out pulse; key/value registers need no reset.

Configuration
REQ-028 SHALL compile replacement logic only when macro CACHE_CTRL_EVICT_EN is defined.
REQ-029 SHALL, with CACHE_CTRL_EVICT_EN, on PUT miss with no free slot overwrite entry victim_ptr (reset 0), set op_succ_out = 1, keep count_out unchanged, and increment victim_ptr modulo NUM_ENTRIES.
REQ-030 SHALL, without CACHE_CTRL_EVICT_EN, on PUT miss with no free slot leave storage unchanged and set op_succ_out = 0.

Verification (NUM_ENTRIES = 4)
REQ-031 SHALL cover: PUT key 0x5 value 0xAB -> done_out exactly 6 cycles after acceptance, op_succ_out = 1, count_out = 1; then GET 0x5 -> value_out = 0xAB, op_succ_out = 1.
REQ-032 SHALL cover: GET key 0x9 on empty store -> op_succ_out = 0, value_out = 0; DELETE 0x9 -> op_succ_out = 0, count_out = 0.
REQ-033 SHALL cover: PUT 0x5=0x1 then PUT 0x5=0x2 -> count_out = 1, GET 0x5 returns 0x2; DELETE 0x5 -> count_out = 0, GET 0x5 fails.
REQ-034 SHALL cover: PUT keys 1-4, then PUT key 5=0x55 -> without macro op_succ_out = 0, count_out = 4, GET 5 fails; with macro op_succ_out = 1, GET 1 fails, GET 5 returns 0x55.
REQ-035 SHALL cover: rst pulsed 2 cycles after accepting PUT 0x7 -> no done_out, count_out = 0, ready_out = 1, later GET 0x7 fails.
REQ-036 SHALL cover: valid_in held high with PUT 0x3 during busy and back-to-back -> exactly one acceptance per 7 cycles, no request lost or duplicated.

Source files
------------

// File: rtl/cache_controller.sv
// Fully associative key/value store scanned one entry per cycle.
// Define CACHE_CTRL_EVICT_EN to enable round-robin replacement when the store is full.
module cache_controller #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 61,
  parameter int VALUE_WIDTH = 128
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_in,
  input  logic [2:0]                         operation_in,
  input  logic [KEY_WIDTH-1:0]               key_in,
  input  logic [VALUE_WIDTH-1:0]             value_in,
  output logic                               ready_out,
  output logic                               done_out,
  output logic                               op_succ_out,
  output logic [VALUE_WIDTH-1:0]             value_out,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   count_out
);
  // state  | meaning
  // IDLE   | ready, accepts a request when valid_in is high
  // SCAN   | compares one entry per cycle, records first hit and lowest free slot
  // COMMIT | applies the storage update and registers the result
  // RESP   | done_out pulse, then back to IDLE
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES+1);
  localparam logic [2:0] OP_GET = 3'd1;
  localparam logic [2:0] OP_PUT = 3'd2;
  localparam logic [2:0] OP_DEL = 3'd3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES-1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_RESP} state_t;

  state_t                 r_state;
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [KEY_WIDTH-1:0]   r_key_mem [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] r_val_mem [NUM_ENTRIES];
  logic [2:0]             r_op;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [VALUE_WIDTH-1:0] r_val;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_hit;
  logic [IDX_W-1:0]       r_hit_idx;
  logic                   r_free;
  logic [IDX_W-1:0]       r_free_idx;
  logic [CNT_W-1:0]       r_count;
  logic                   r_done;
  logic                   r_succ;
  logic [VALUE_WIDTH-1:0] r_value;
`ifdef CACHE_CTRL_EVICT_EN
  logic [IDX_W-1:0]       r_victim;
  logic                   w_evict;
`endif

  logic                   w_match;
  logic                   w_wr_en;
  logic [IDX_W-1:0]       w_wr_idx;
  logic                   w_set_valid;
  logic                   w_clr_valid;
  logic                   w_succ;

  assign w_match     = r_valid[r_idx] && (r_key_mem[r_idx] == r_key);
  assign ready_out   = (r_state == S_IDLE);
  assign done_out    = r_done;
  assign op_succ_out = r_succ;
  assign value_out   = r_value;
  assign count_out   = r_count;

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = r_hit_idx;
    w_set_valid = 1'b0;
    w_clr_valid = 1'b0;
    w_succ      = 1'b0;
`ifdef CACHE_CTRL_EVICT_EN
    w_evict     = 1'b0;
`endif
    case (r_op)
      OP_GET: w_succ = r_hit;
      OP_PUT: begin
        if (r_hit) begin
          w_wr_en = 1'b1;
          w_succ  = 1'b1;
        end else if (r_free) begin
          w_wr_en     = 1'b1;
          w_wr_idx    = r_free_idx;
          w_set_valid = 1'b1;
          w_succ      = 1'b1;
        end else begin
`ifdef CACHE_CTRL_EVICT_EN
          // store is full: every slot is valid, so count stays put
          w_wr_en  = 1'b1;
          w_wr_idx = r_victim;
          w_evict  = 1'b1;
          w_succ   = 1'b1;
`endif
        end
      end
      OP_DEL: begin
        w_clr_valid = r_hit;
        w_succ      = r_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_succ     <= 1'b0;
      r_value    <= '0;
      r_idx      <= '0;
      r_hit      <= 1'b0;
      r_hit_idx  <= '0;
      r_free     <= 1'b0;
      r_free_idx <= '0;
`ifdef CACHE_CTRL_EVICT_EN
      r_victim   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
            r_hit   <= 1'b0;
            r_free  <= 1'b0;
          end
        end
        S_SCAN: begin
          if (!r_hit && w_match) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_idx;
          end
          if (!r_free && !r_valid[r_idx]) begin
            r_free     <= 1'b1;
            r_free_idx <= r_idx;
          end
          if (r_idx == LAST_IDX) r_state <= S_COMMIT;
          else                   r_idx   <= r_idx + 1'b1;
        end
        S_COMMIT: begin
          if (w_set_valid && r_count < MAX_CNT) begin
            r_valid[w_wr_idx] <= 1'b1;
            r_count           <= r_count + 1'b1;
          end
          if (w_clr_valid && r_count != '0) begin
            r_valid[r_hit_idx] <= 1'b0;
            r_count            <= r_count - 1'b1;
          end
`ifdef CACHE_CTRL_EVICT_EN
          if (w_evict) r_victim <= r_victim + 1'b1;
`endif
          r_succ  <= w_succ;
          r_value <= (r_op == OP_GET && r_hit) ? r_val_mem[r_hit_idx] : '0;
          r_done  <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // payload storage carries no reset; the valid bits alone define contents
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && valid_in) begin
      r_op  <= operation_in;
      r_key <= key_in;
      r_val <= value_in;
    end
    if (r_state == S_COMMIT && w_wr_en && !rst) begin
      r_key_mem[w_wr_idx] <= r_key;
      r_val_mem[w_wr_idx] <= r_val;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller with NUM_ENTRIES = 4; expectations follow
// CACHE_CTRL_EVICT_EN when the bench is built with that macro.
module tb_cache_controller;
  localparam int N = 4;
  localparam logic [2:0] NOOP = 3'd0, GET = 3'd1, PUT = 3'd2, DEL = 3'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_in = 1'b0;
  logic [2:0]   operation_in = '0;
  logic [60:0]  key_in = '0;
  logic [127:0] value_in = '0;
  logic         ready_out, done_out, op_succ_out;
  logic [127:0] value_out;
  logic [2:0]   count_out;

  cache_controller #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .operation_in(operation_in),
    .key_in(key_in), .value_in(value_in), .ready_out(ready_out),
    .done_out(done_out), .op_succ_out(op_succ_out), .value_out(value_out),
    .count_out(count_out));

  always #5 clk = ~clk;

  typedef struct {
    logic         succ;
    logic [127:0] val;
    logic [2:0]   cnt;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done_out) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_out=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("op_succ", op_succ_out, e.succ);
        chk("value", value_out, e.val);
        chk("count", count_out, e.cnt);
        chk("latency", cyc - e.acc, N + 2);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic issue(input logic [2:0] op, input logic [60:0] k, input logic [127:0] v,
                       input logic es, input logic [127:0] ev, input logic [2:0] ec);
    exp_t e;
    int   n = 0;
    while (!ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      chk("ready_timeout", ready_out, 1'b1);
      return;
    end
    operation_in = op;
    key_in       = k;
    value_in     = v;
    valid_in     = 1'b1;
    e.succ = es; e.val = ev; e.cnt = ec; e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    valid_in = 1'b0;
    wait_drain();
  endtask

  initial begin
    int acc_t[3];
    int acc_n;

    do_reset();
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_done", done_out, 1'b0);
    chk("rst_succ", op_succ_out, 1'b0);
    chk("rst_value", value_out, 128'h0);
    chk("rst_count", count_out, 3'd0);

    issue(PUT, 61'h5, 128'hAB, 1'b1, 128'h0, 3'd1);
    issue(GET, 61'h5, 128'h0, 1'b1, 128'hAB, 3'd1);

    do_reset();
    issue(GET, 61'h9, 128'h0, 1'b0, 128'h0, 3'd0);
    issue(DEL, 61'h9, 128'h0, 1'b0, 128'h0, 3'd0);

    issue(PUT, 61'h5, 128'h1, 1'b1, 128'h0, 3'd1);
    issue(PUT, 61'h5, 128'h2, 1'b1, 128'h0, 3'd1);
    issue(GET, 61'h5, 128'h0, 1'b1, 128'h2, 3'd1);
    issue(DEL, 61'h5, 128'h0, 1'b1, 128'h0, 3'd0);
    issue(GET, 61'h5, 128'h0, 1'b0, 128'h0, 3'd0);

    issue(PUT, 61'h6, 128'h66, 1'b1, 128'h0, 3'd1);
    issue(NOOP, 61'h6, 128'h99, 1'b0, 128'h0, 3'd1);
    issue(3'd5, 61'h6, 128'h99, 1'b0, 128'h0, 3'd1);
    issue(GET, 61'h6, 128'h0, 1'b1, 128'h66, 3'd1);

    // fill the store, then overflow it
    do_reset();
    for (int i = 1; i <= 4; i++)
      issue(PUT, 61'(i), 128'(i * 'h11), 1'b1, 128'h0, 3'(i));
`ifdef CACHE_CTRL_EVICT_EN
    issue(PUT, 61'h5, 128'h55, 1'b1, 128'h0, 3'd4);
    issue(GET, 61'h1, 128'h0, 1'b0, 128'h0, 3'd4);
    issue(GET, 61'h5, 128'h0, 1'b1, 128'h55, 3'd4);
    issue(GET, 61'h2, 128'h0, 1'b1, 128'h22, 3'd4);
    issue(PUT, 61'h6, 128'h66, 1'b1, 128'h0, 3'd4);
    issue(GET, 61'h2, 128'h0, 1'b0, 128'h0, 3'd4);
`else
    issue(PUT, 61'h5, 128'h55, 1'b0, 128'h0, 3'd4);
    issue(GET, 61'h5, 128'h0, 1'b0, 128'h0, 3'd4);
    issue(GET, 61'h1, 128'h0, 1'b1, 128'h11, 3'd4);
    issue(PUT, 61'h6, 128'h66, 1'b0, 128'h0, 3'd4);
`endif
    issue(DEL, 61'h3, 128'h0, 1'b1, 128'h0, 3'd3);
    issue(PUT, 61'h7, 128'h77, 1'b1, 128'h0, 3'd4);
    issue(GET, 61'h7, 128'h0, 1'b1, 128'h77, 3'd4);

    // reset aborts an in-flight PUT
    do_reset();
    operation_in = PUT;
    key_in       = 61'h7;
    value_in     = 128'h70;
    valid_in     = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready_async", ready_out, 1'b1);
    chk("abort_count_async", count_out, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_ready", ready_out, 1'b1);
    chk("abort_count", count_out, 3'd0);
    issue(GET, 61'h7, 128'h0, 1'b0, 128'h0, 3'd0);

    // valid_in held high across busy periods
    do_reset();
    operation_in = PUT;
    key_in       = 61'h3;
    value_in     = 128'h33;
    valid_in     = 1'b1;
    acc_n = 0;
    for (int c = 0; c < 60 && acc_n < 3; c++) begin
      if (ready_out) begin
        exp_t e;
        e.succ = 1'b1; e.val = 128'h0; e.cnt = 3'd1; e.acc = cyc;
        q.push_back(e);
        acc_t[acc_n] = cyc;
        acc_n++;
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    wait_drain();
    chk("b2b_accepts", acc_n, 3);
    chk("b2b_gap1", acc_t[1] - acc_t[0], N + 3);
    chk("b2b_gap2", acc_t[2] - acc_t[1], N + 3);
    issue(GET, 61'h3, 128'h0, 1'b1, 128'h33, 3'd1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
